// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake plus serial line and status between the CPU side and the UART transmitter.
// master = CPU side driving bytes; slave = transmitter.
interface uart_tx_fifo_if #(
    parameter int LVL_W = 3
);
    logic             io_tx_valid;
    logic [7:0]       io_tx_data;
    logic             io_tx_ready;
    logic             io_tx;
    logic             io_busy;
    logic [LVL_W-1:0] io_level;

    modport master (
        output io_tx_valid,
        output io_tx_data,
        input  io_tx_ready,
        input  io_tx,
        input  io_busy,
        input  io_level
    );

    modport slave (
        input  io_tx_valid,
        input  io_tx_data,
        output io_tx_ready,
        output io_tx,
        output io_busy,
        output io_level
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; a byte pushed while idle reaches the line 1 cycle later.
// Backpressure: io_tx_ready = !full, a push is refused while full even if a pop happens on that edge.
module uart_tx_fifo #(
    parameter int  CLK_DIV    = 868,
    parameter int  FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            r_state;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;

    logic w_full;
    logic w_empty;
    logic w_bit_end;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_bit_end = (r_baud == '0);
    assign w_push    = bus.io_tx_valid && !w_full;
    // Pop when idle or at the end of a stop bit, so queued frames run back-to-back.
    assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    assign bus.io_tx_ready = !w_full;
    assign bus.io_tx       = r_tx;
    assign bus.io_level    = r_count;
    assign bus.io_busy     = (r_state != IDLE) || !w_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.io_tx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= BAUD_LOAD;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud    <= BAUD_LOAD;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= BAUD_LOAD;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_baud  <= BAUD_LOAD;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
